// File: rtl/echo_dist_scan_if.sv
// Signal bundle for echo_dist_scan: raw echo lines in, trigger pulses and
// per-channel filtered BCD distances out. master = scanner, slave = sensors/consumers.
interface echo_dist_scan_if #(
    parameter int NCH    = 2,
    parameter int DIGITS = 4
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]          echo_in;
    logic [NCH-1:0]          trig_out;
    logic [NCH*4*DIGITS-1:0] dist_bcd;
    logic                    dist_valid;
    logic [CHW-1:0]          dist_ch;
    logic [NCH-1:0]          dist_timeout;

    modport master (
        input  echo_in,
        output trig_out, dist_bcd, dist_valid, dist_ch, dist_timeout
    );

    modport slave (
        output echo_in,
        input  trig_out, dist_bcd, dist_valid, dist_ch, dist_timeout
    );
endinterface

// File: rtl/echo_dist_scan.sv
// Round-robin ultrasonic range scanner: trigger, echo timing with a saturating BCD
// counter, per-channel absolute-difference hysteresis (enabled by ECHO_DIST_HYST_EN).
module echo_dist_scan #(
    parameter int NCH         = 2,
    parameter int DIGITS      = 4,
    parameter int TICK_DIV    = 1,
    parameter int TRIG_CYCLES = 1000,
    parameter int WAIT_CYCLES = 3000000,
    parameter int GAP_CYCLES  = 6000000,
    parameter int HYST        = 3
) (
    input  logic             clk_in,
    input  logic             rst_n,
    echo_dist_scan_if.master bus
);
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DW      = 4 * DIGITS;
    localparam int BIN_MAX = 10**DIGITS - 1;
    localparam int BW      = $clog2(BIN_MAX + 1);
    localparam int TW_MAX  = (TRIG_CYCLES > WAIT_CYCLES) ? TRIG_CYCLES : WAIT_CYCLES;
    localparam int CNT_MAX = (TW_MAX > GAP_CYCLES) ? TW_MAX : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] ALL9 = {DIGITS{4'h9}};
`ifdef ECHO_DIST_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif
    // A negative threshold lets every non-timeout reading through.
    localparam int HYST_EFF = HYST_ON ? HYST : -1;

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_UPD, S_GAP
    } state_t;

    state_t                   state_q, state_d;
    logic [CHW-1:0]           ch_q, ch_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [PW-1:0]            presc_q, presc_d;
    logic [DW-1:0]            bcd_q, bcd_d;
    logic [BW-1:0]            bin_q, bin_d;
    logic                     sat_q, sat_d;
    logic [NCH-1:0]           sync1_q, es_q;
    logic [NCH-1:0]           trig_q, trig_d;
    logic [NCH-1:0][DW-1:0]   dist_q, dist_d;
    logic [NCH-1:0][BW-1:0]   stored_q, stored_d;
    logic                     valid_q, valid_d;
    logic [CHW-1:0]           dist_ch_q, dist_ch_d;
    logic [NCH-1:0]           tmo_q, tmo_d;

    logic                     es_sel, count_en, upd_go, upd_timeout, sat_base;
    logic [PW-1:0]            presc_base;
    logic [DW-1:0]            bcd_base;
    logic [BW-1:0]            bin_base, stored_sel, diff;

    function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        presc_d     = presc_q;
        bcd_d       = bcd_q;
        bin_d       = bin_q;
        sat_d       = sat_q;
        trig_d      = '0;
        dist_d      = dist_q;
        stored_d    = stored_q;
        valid_d     = 1'b0;
        dist_ch_d   = dist_ch_q;
        tmo_d       = tmo_q;
        count_en    = 1'b0;
        upd_go      = 1'b0;
        upd_timeout = 1'b0;
        presc_base  = presc_q;
        bcd_base    = bcd_q;
        bin_base    = bin_q;
        sat_base    = sat_q;
        es_sel      = es_q[ch_q];
        stored_sel  = stored_q[ch_q];
        diff        = (bin_q >= stored_sel) ? (bin_q - stored_sel) : (stored_sel - bin_q);

        case (state_q)
            S_IDLE: begin
                state_d = S_TRIG;
                ch_d    = '0;
                cnt_d   = '0;
            end
            S_TRIG: begin
                if (cnt_q == CW'(TRIG_CYCLES - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                // The cycle that sees the rise is itself the first counted cycle.
                if (es_sel) begin
                    state_d    = S_MEAS;
                    cnt_d      = '0;
                    count_en   = 1'b1;
                    presc_base = '0;
                    bcd_base   = '0;
                    bin_base   = '0;
                    sat_base   = 1'b0;
                end else if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
                    state_d     = S_UPD;
                    cnt_d       = '0;
                    upd_go      = 1'b1;
                    upd_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MEAS: begin
                if (!es_sel) begin
                    state_d = S_UPD;
                    upd_go  = 1'b1;
                end else begin
                    count_en = 1'b1;
                end
            end
            S_UPD: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    state_d = S_TRIG;
                    cnt_d   = '0;
                    ch_d    = (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + CHW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (count_en) begin
            bcd_d   = bcd_base;
            bin_d   = bin_base;
            sat_d   = sat_base;
            presc_d = presc_base + PW'(1);
            if (presc_base == PW'(TICK_DIV - 1)) begin
                presc_d = '0;
                if (bcd_base != ALL9) begin
                    bcd_d = bcd_inc(bcd_base);
                    bin_d = bin_base + BW'(1);
                end
                sat_d = (bcd_d == ALL9);
            end
        end

        // Results land on the edge that enters UPDATE, together with dist_valid.
        if (upd_go) begin
            valid_d   = 1'b1;
            dist_ch_d = ch_q;
            if (upd_timeout) begin
                tmo_d[ch_q] = 1'b1;
            end else if (sat_q) begin
                tmo_d[ch_q]    = 1'b1;
                dist_d[ch_q]   = ALL9;
                stored_d[ch_q] = BW'(BIN_MAX);
            end else begin
                tmo_d[ch_q] = 1'b0;
                if (int'(diff) > HYST_EFF) begin
                    dist_d[ch_q]   = bcd_q;
                    stored_d[ch_q] = bin_q;
                end
            end
        end

        if (state_d == S_TRIG) begin
            trig_d[ch_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            presc_q   <= '0;
            bcd_q     <= '0;
            bin_q     <= '0;
            sat_q     <= 1'b0;
            sync1_q   <= '0;
            es_q      <= '0;
            trig_q    <= '0;
            dist_q    <= '0;
            stored_q  <= '0;
            valid_q   <= 1'b0;
            dist_ch_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            sat_q     <= sat_d;
            sync1_q   <= bus.echo_in;
            es_q      <= sync1_q;
            trig_q    <= trig_d;
            dist_q    <= dist_d;
            stored_q  <= stored_d;
            valid_q   <= valid_d;
            dist_ch_q <= dist_ch_d;
            tmo_q     <= tmo_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_dist
            assign bus.dist_bcd[gi*DW +: DW] = dist_q[gi];
        end
    endgenerate

    assign bus.trig_out     = trig_q;
    assign bus.dist_valid   = valid_q;
    assign bus.dist_ch      = dist_ch_q;
    assign bus.dist_timeout = tmo_q;
endmodule

// File: tb/tb_echo_dist_scan.sv
// Self-checking bench for echo_dist_scan: directed and randomized echo lengths
// against a per-channel distance model; follows ECHO_DIST_HYST_EN like the design.
module tb_echo_dist_scan;
    localparam int NCH         = 2;
    localparam int DIGITS      = 2;
    localparam int TICK_DIV    = 1;
    localparam int TRIG_CYCLES = 4;
    localparam int WAIT_CYCLES = 20;
    localparam int GAP_CYCLES  = 8;
    localparam int HYST        = 3;
    localparam int DW          = 4 * DIGITS;
    localparam int MAXV        = 10**DIGITS - 1;
`ifdef ECHO_DIST_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst_n  = 1'b1;
    always #5 clk_in = ~clk_in;

    echo_dist_scan_if #(.NCH(NCH), .DIGITS(DIGITS)) bus ();

    echo_dist_scan #(
        .NCH(NCH), .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .TRIG_CYCLES(TRIG_CYCLES),
        .WAIT_CYCLES(WAIT_CYCLES), .GAP_CYCLES(GAP_CYCLES), .HYST(HYST)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_dist [NCH];
    bit exp_to   [NCH];
    int exp_ch;
    int next_lat;

    function automatic logic [NCH*DW-1:0] exp_bcd();
        logic [NCH*DW-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            v = exp_dist[k];
            for (int g = 0; g < DIGITS; g++) begin
                r[k*DW + g*4 +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_tmo();
        logic [NCH-1:0] r;
        for (int k = 0; k < NCH; k++) r[k] = exp_to[k];
        return r;
    endfunction

    // len == 0 means no echo at all; a reading of MAXV counts or more saturates.
    task automatic model_measure(input int ch, input int len);
        int d;
        if (len == 0) begin
            exp_to[ch] = 1'b1;
        end else if (len >= MAXV) begin
            exp_to[ch]   = 1'b1;
            exp_dist[ch] = MAXV;
        end else begin
            exp_to[ch] = 1'b0;
            d = len - exp_dist[ch];
            if (d < 0) d = -d;
            if (!HYST_ON || d > HYST) exp_dist[ch] = len;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            exp_dist[k] = 0;
            exp_to[k]   = 1'b0;
        end
        exp_ch   = 0;
        next_lat = 1;
    endtask

    // One full measurement cycle on the expected channel.
    task automatic run_meas(input int len, input int dly);
        int n, w, vcnt, ch, oth, lat_exp;
        logic [NCH-1:0] oh;
        ch  = exp_ch;
        oth = (ch + 1) % NCH;
        oh  = '0;
        oh[ch] = 1'b1;
        n    = 0;
        vcnt = 0;
        do begin
            @(negedge clk_in);
            n++;
            if (bus.dist_valid) vcnt++;
        end while (bus.trig_out == '0 && n < 200);
        checks++;
        if (n != next_lat || bus.trig_out !== oh) begin
            errors++;
            $display("FAIL trig_start: got delay %0d trig_out %b, want delay %0d trig_out %b",
                     n, bus.trig_out, next_lat, oh);
        end
        checks++;
        if (vcnt != 0) begin
            errors++;
            $display("FAIL valid_gap: got %0d extra dist_valid cycles, want 0", vcnt);
        end
        w = 0;
        while (bus.trig_out == oh && w < 100) begin
            w++;
            @(negedge clk_in);
        end
        checks++;
        if (w != TRIG_CYCLES || bus.trig_out !== '0) begin
            errors++;
            $display("FAIL trig_width: got %0d cycles then trig_out %b, want %0d then 0",
                     w, bus.trig_out, TRIG_CYCLES);
        end
        if (len > 0) begin
            for (int i = 0; i < dly; i++) begin
                bus.echo_in[oth] = 1'($urandom);
                @(negedge clk_in);
            end
            bus.echo_in[ch] = 1'b1;
            for (int i = 0; i < len; i++) begin
                @(negedge clk_in);
                bus.echo_in[oth] = 1'($urandom);
            end
            bus.echo_in = '0;
            lat_exp = 3;
        end else begin
            lat_exp = WAIT_CYCLES;
        end
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
            if (len == 0) bus.echo_in[oth] = 1'($urandom);
        end while (!bus.dist_valid && n < 300);
        bus.echo_in = '0;
        model_measure(ch, len);
        checks++;
        if (n != lat_exp) begin
            errors++;
            $display("FAIL valid_latency: ch%0d len %0d got %0d cycles, want %0d", ch, len, n, lat_exp);
        end
        checks++;
        if (bus.dist_ch !== 1'(ch)) begin
            errors++;
            $display("FAIL dist_ch: got %0d, want %0d", bus.dist_ch, ch);
        end
        checks++;
        if (bus.dist_bcd !== exp_bcd()) begin
            errors++;
            $display("FAIL dist_bcd: ch%0d len %0d got %h, want %h", ch, len, bus.dist_bcd, exp_bcd());
        end
        checks++;
        if (bus.dist_timeout !== exp_tmo()) begin
            errors++;
            $display("FAIL dist_timeout: ch%0d len %0d got %b, want %b", ch, len, bus.dist_timeout, exp_tmo());
        end
        $display("meas ch=%0d len=%0d delay=%0d dist_bcd=%h timeout=%b", ch, len, dly,
                 bus.dist_bcd, bus.dist_timeout);
        exp_ch   = oth;
        next_lat = GAP_CYCLES + 1;
    endtask

    task automatic test_reset();
        bus.echo_in = '0;
        #3;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (bus.trig_out !== '0 || bus.dist_bcd !== '0 || bus.dist_valid !== 1'b0 ||
            bus.dist_ch !== '0 || bus.dist_timeout !== '0) begin
            errors++;
            $display("FAIL reset_state: got trig %b bcd %h valid %b ch %0d tmo %b, want all 0",
                     bus.trig_out, bus.dist_bcd, bus.dist_valid, bus.dist_ch, bus.dist_timeout);
        end
        model_reset();
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic();
        run_meas(37, 3);
        run_meas(0, 0);
        run_meas(39, 5);
        run_meas(150, 1);
        run_meas(41, 0);
        run_meas(50, 7);
    endtask

    task automatic test_boundary();
        run_meas(98, 2);
        run_meas(99, 4);
        run_meas(95, 0);
        run_meas(1, 9);
        run_meas(94, 12);
        run_meas(4, 3);
        run_meas(0, 0);
        run_meas(5, 6);
    endtask

    task automatic test_random();
        int len, dly;
        for (int i = 0; i < 16; i++) begin
            len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 110));
            dly = int'($urandom_range(0, 12));
            run_meas(len, dly);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        if (exp_ch != 0) run_meas(20, 2);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (bus.trig_out == '0 && n < 200);
        n = 0;
        while (bus.trig_out != '0 && n < 100) begin
            n++;
            @(negedge clk_in);
        end
        bus.echo_in[0] = 1'b1;
        repeat (12) @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.trig_out !== '0 || bus.dist_bcd !== '0 || bus.dist_valid !== 1'b0 ||
            bus.dist_ch !== '0 || bus.dist_timeout !== '0) begin
            errors++;
            $display("FAIL reset_mid: got trig %b bcd %h valid %b ch %0d tmo %b, want all 0",
                     bus.trig_out, bus.dist_bcd, bus.dist_valid, bus.dist_ch, bus.dist_timeout);
        end
        bus.echo_in = '0;
        repeat (3) @(negedge clk_in);
        model_reset();
        rst_n = 1'b1;
        $display("reset pulsed mid-measurement and released");
    endtask

    task automatic test_after_reset();
        run_meas(37, 2);
        run_meas(0, 0);
        run_meas(39, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_random();
        test_reset_mid();
        test_after_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
